ct_f_spsram_access_ctrl: RTL and testbench
==========================================

Name: ct_f_spsram_access_ctrl

Overview:
- Request-side controller placed directly upstream of the FPGA single-port SRAM model (A/CEN/GWEN/WEN/D/Q, active-low enables, 1-cycle synchronous read).
- Converts a valid/ready read/write request stream into registered SRAM pin controls, and returns read data on a valid/ready response channel through a credit-limited FIFO.
- After reset, optionally clears the whole array with INIT_VALUE before accepting traffic.

Parameters:
ADDR_WIDTH, 16, SRAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 128, SRAM data width
RESP_DEPTH, 4, response FIFO entries (power of 2, >=4)
INIT_EN, 1, 1 = clear array after reset; 0 = go straight to RUN
INIT_VALUE, 0, DATA_WIDTH-wide value written during INIT

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  asynchronous active-low reset
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  active-high bit write enable
resp_vld  out  1  read data valid
resp_rdy  in  1  consumer ready
resp_rdata  out  DATA_WIDTH  read data
init_done  out  1  high once INIT has completed
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN (active low)
sram_gwen  out  1  to SRAM GWEN (active low write)
sram_wen  out  DATA_WIDTH  to SRAM WEN (active-low bit mask)
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst_b is asynchronous and active-low.
- Reset values:
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
  - req_rdy=0, resp_vld=0, init_done=0.
  - FIFO empty, outstanding=0, init counter=0.
  - State is INIT if INIT_EN, else RUN.
- All sram_* outputs are registered.
- FSM states:
  - INIT: each cycle drive cen=0, gwen=0, wen=0, a=counter, d=INIT_VALUE; counter increments. When counter reaches 2^ADDR_WIDTH-1, that write is issued and the FSM goes to RUN. INIT takes 2^ADDR_WIDTH cycles. req_rdy=0 throughout.
  - RUN: init_done=1 (registered, rises in the first RUN cycle); no exit except reset.
- req_rdy in RUN:
  - Writes: req_rdy=1.
  - Reads: req_rdy = (outstanding < RESP_DEPTH).
  - req_rdy is a function of req_wr and registered state only.
- Accepted request at cycle T: at T+1 sram pins reflect it (cen=0, a=req_addr).
  - Write: gwen=0, wen=~req_wmask, d=req_wdata.
  - Read: gwen=1, wen=all 1.
  - No accept at T: at T+1 cen=1, gwen=1, wen=all 1; a and d hold their previous values.
- Read pipeline:
  - SRAM samples at the end of T+1; sram_q is captured into the FIFO at the end of T+2.
  - resp_vld rises at T+3, so read latency from accept to resp_vld is 3 cycles.
  - Back-to-back reads give one response per cycle.
- Writes are posted and produce no response.
- Order is strictly program order (single port), so a read after a write to the same address returns the new data.
- Outstanding counter:
  - +1 on read accept, -1 on resp_vld & resp_rdy; both in the same cycle means no change.
  - Never exceeds RESP_DEPTH, and the FIFO can never overflow.
- Response FIFO: resp_rdata is the head entry and is stable while resp_vld & !resp_rdy. Pointers wrap modulo RESP_DEPTH.
- Mask rules:
  - req_wmask=0 on a write still issues cen=0, gwen=0 with wen=all 1, so no bits change.
  - Unmasked bits retain their old value.
- Reset mid-operation: all in-flight reads and FIFO contents are discarded, outputs return to reset values, and INIT restarts from address 0.

Decomposition:
- Package ct_f_spsram_ctrl_pkg: state enum {INIT, RUN} and a request struct {wr, addr, wdata, wmask}.
- One sub-module, ct_f_spsram_resp_fifo: parameterised synchronous FIFO with push/pop/head/count on the same clock and reset.
- FSM, pin registers and credit counter stay in the top module.

Test Plan:
- INIT_EN=1, ADDR_WIDTH=4, INIT_VALUE=0: release reset -> 16 consecutive cycles with cen=0, gwen=0, a=0..15; init_done=1 on cycle 17; a read of addr 7 returns 0.
- Write addr 3 data 0xA5A5, mask all 1; then read addr 3 -> resp_vld exactly 3 cycles after the read accept, resp_rdata=0xA5A5.
- Partial write: addr 3 holds 0xFFFF; write data 0x0000 with mask 0x00FF -> read returns 0xFF00.
- Hold resp_rdy=0 and issue 6 reads -> 4 accepted, req_rdy low for reads while writes are still accepted; raise resp_rdy -> 4 responses in order, then the remaining reads proceed.
- Streaming reads of addr 0..7 with resp_rdy=1 -> one response per cycle, data in address order, no bubbles after the initial 3-cycle latency.
- Assert cpurst_b low with 2 reads in flight and 1 buffered -> resp_vld=0 immediately, no stale responses after release, INIT restarts at a=0.

Source files
------------

// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types for the single-port SRAM access controller.
package ct_f_spsram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // SRAM enables are active-low
  localparam logic EN_ON  = 1'b0;
  localparam logic EN_OFF = 1'b1;

endpackage

// File: rtl/ct_f_spsram_resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH (power of 2).
module ct_f_spsram_resp_fifo #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [PTR_W:0]        count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  pop_eff;

  assign pop_eff = pop & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ct_f_spsram_access_ctrl.sv
// Request-side controller for a 1-cycle single-port SRAM: registered pin
// drive, optional post-reset clear, credit-limited read response channel.
module ct_f_spsram_access_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           RESP_DEPTH = 4,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  resp_vld,
  input  logic                  resp_rdy,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned       CNT_W     = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CREDITS   = CNT_W'(RESP_DEPTH);
  localparam ctrl_state_e       RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] wmask;
  } req_t;

  req_t                  req;
  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_done_q;
  logic [CNT_W-1:0]      outstanding;
  logic                  req_acc, rd_acc, resp_pop;
  logic                  rd_vld_p1, rd_vld_p2;
  logic [CNT_W-1:0]      fifo_count;
  logic                  cen_d, gwen_d;
  logic [DATA_WIDTH-1:0] wen_d, d_d;
  logic [ADDR_WIDTH-1:0] a_d;

  assign req = '{wr: req_wr, addr: req_addr, wdata: req_wdata, wmask: req_wmask};

  // Writes are posted; reads need a free response credit
  assign req_rdy   = init_done_q & (req.wr | (outstanding < CREDITS));
  assign req_acc   = req_vld & req_rdy;
  assign rd_acc    = req_acc & ~req.wr;
  assign resp_vld  = (fifo_count != '0);
  assign resp_pop  = resp_vld & resp_rdy;
  assign init_done = init_done_q;

  always_comb begin
    state_d = state_q;
    cen_d   = EN_OFF;
    gwen_d  = EN_OFF;
    wen_d   = '1;
    a_d     = sram_a;
    d_d     = sram_d;
    if (state_q == ST_INIT) begin
      cen_d  = EN_ON;
      gwen_d = EN_ON;
      wen_d  = '0;
      a_d    = init_cnt;
      d_d    = INIT_VALUE;
      if (init_cnt == '1) state_d = ST_RUN;
    end else if (req_acc) begin
      cen_d = EN_ON;
      a_d   = req.addr;
      if (req.wr) begin
        gwen_d = EN_ON;
        wen_d  = ~req.wmask;
        d_d    = req.wdata;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= RST_STATE;
      init_cnt    <= '0;
      init_done_q <= 1'b0;
      outstanding <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_q | (state_q == ST_RUN);
      if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
      unique case ({rd_acc, resp_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage p0 -> p1: SRAM pin registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sram_cen  <= EN_OFF;
      sram_gwen <= EN_OFF;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else begin
      sram_cen  <= cen_d;
      sram_gwen <= gwen_d;
      sram_wen  <= wen_d;
      sram_a    <= a_d;
      sram_d    <= d_d;
    end
  end

  // Stage p1 -> p2: SRAM samples, Q valid one cycle later and is pushed
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_p1 <= 1'b0;
      rd_vld_p2 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_acc;
      rd_vld_p2 <= rd_vld_p1;
    end
  end

  ct_f_spsram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_resp_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .push           (rd_vld_p2),
    .push_data      (sram_q),
    .pop            (resp_pop),
    .head           (resp_rdata),
    .count          (fifo_count)
  );

endmodule

// File: tb/tb_ct_f_spsram_access_ctrl.sv
// Directed bench for ct_f_spsram_access_ctrl with a behavioural 1-cycle SRAM.
module tb_ct_f_spsram_access_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          forever_cpuclk;
  logic          cpurst_b;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          resp_vld, resp_rdy;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  int n_cmp = 0;
  int n_mis = 0;

  logic          preload;
  logic [DW-1:0] mem [1<<AW];

  ct_f_spsram_access_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESP_DEPTH (4),
    .INIT_EN    (1'b1),
    .INIT_VALUE (16'h0000)
  ) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .resp_vld       (resp_vld),
    .resp_rdy       (resp_rdy),
    .resp_rdata     (resp_rdata),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Behavioural SRAM: bit-masked write, synchronous read; preload marks unwritten words
  always @(posedge forever_cpuclk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'hDEAD;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      sram_q <= mem[sram_a];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    chk("wr_rdy", req_rdy, 1);
    tick();
    req_vld = 1'b0;
    chk("wr_pins", {sram_cen, sram_gwen, sram_a, sram_wen, sram_d}, {1'b0, 1'b0, a, ~m, d});
  endtask

  // Assumes resp_rdy=1 and an empty response path
  task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    #1;
    chk("rd_rdy", req_rdy, 1);
    tick();
    req_vld = 1'b0;
    chk("rd_pins", {sram_cen, sram_gwen, sram_a, sram_wen}, {1'b0, 1'b1, a, 16'hFFFF});
    chk("rd_lat1", resp_vld, 0);
    tick();
    chk("rd_lat2", resp_vld, 0);
    tick();
    chk("rd_vld", resp_vld, 1);
    chk("rd_data", resp_rdata, exp);
    tick();
    chk("rd_popped", resp_vld, 0);
  endtask

  initial begin
    cpurst_b = 1'b0; preload = 1'b1;
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_rdy = 1'b1;
    tick(); tick(); tick();
    preload = 1'b0;

    // Reset values
    chk("rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 1'b1, 16'hFFFF, 4'h0, 16'h0});
    chk("rst_ctl", {req_rdy, resp_vld, init_done}, 3'b000);

    // INIT walk
    cpurst_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("init_pins", {sram_cen, sram_gwen, sram_wen, sram_d, sram_a}, {1'b0, 1'b0, 16'h0, 16'h0, 4'(k)});
      chk("init_ctl", {req_rdy, init_done}, 2'b00);
    end
    tick();
    chk("init_done", init_done, 1);
    chk("post_init_idle", {sram_cen, sram_gwen, sram_wen}, {1'b1, 1'b1, 16'hFFFF});

    do_rd(4'd7, 16'h0000);

    // Full write then read-back
    do_wr(4'd3, 16'hA5A5, 16'hFFFF);
    do_rd(4'd3, 16'hA5A5);

    // Partial and zero-mask writes
    do_wr(4'd3, 16'hFFFF, 16'hFFFF);
    do_wr(4'd3, 16'h0000, 16'h00FF);
    do_rd(4'd3, 16'hFF00);
    do_wr(4'd3, 16'h1234, 16'h0000);
    do_rd(4'd3, 16'hFF00);

    for (int i = 0; i < 8; i++) do_wr(4'(i), 16'h1000 + 16'(i), 16'hFFFF);

    // Backpressure: four credits, writes still flow
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'(i);
      #1;
      chk("bp_rdy", req_rdy, 1);
      tick();
    end
    req_addr = 4'd4;
    #1;
    chk("bp_block", req_rdy, 0);
    req_wr = 1'b1; req_addr = 4'd9; req_wdata = 16'h9999; req_wmask = 16'hFFFF;
    #1;
    chk("bp_wr_rdy", req_rdy, 1);
    tick();
    chk("bp_wr_pins", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b0, 4'd9});
    req_wr = 1'b0; req_addr = 4'd4;
    #1;
    chk("bp_block2", req_rdy, 0);
    tick(); tick();
    chk("bp_head_vld", resp_vld, 1);
    chk("bp_head", resp_rdata, 16'h1000);
    chk("bp_still_blocked", req_rdy, 0);
    tick();
    chk("bp_head_stable", resp_rdata, 16'h1000);
    req_vld = 1'b0; resp_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_vld", resp_vld, 1);
      chk("bp_drain_data", resp_rdata, 16'h1000 + 16'(j));
      tick();
    end
    chk("bp_drained", resp_vld, 0);
    do_rd(4'd4, 16'h1004);
    do_rd(4'd5, 16'h1005);

    // Streaming reads
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'(c);
        #1;
        chk("st_rdy", req_rdy, 1);
      end else begin
        req_vld = 1'b0;
      end
      tick();
      if (c >= 2 && c <= 9) begin
        chk("st_vld", resp_vld, 1);
        chk("st_data", resp_rdata, 16'h1000 + 16'(c - 2));
      end else begin
        chk("st_idle", resp_vld, 0);
      end
    end

    // Reset with two reads in flight and one buffered
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'(i);
      tick();
    end
    req_vld = 1'b0;
    chk("mid_buffered", resp_vld, 1);
    cpurst_b = 1'b0;
    #1;
    chk("mid_rst_ctl", {resp_vld, req_rdy, init_done}, 3'b000);
    chk("mid_rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a}, {1'b1, 1'b1, 16'hFFFF, 4'h0});
    tick(); tick();
    cpurst_b = 1'b1;
    resp_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("reinit_pins", {sram_cen, sram_gwen, sram_a}, {1'b0, 1'b0, 4'(k)});
      chk("reinit_no_resp", resp_vld, 0);
    end
    tick();
    chk("reinit_done", init_done, 1);
    chk("reinit_no_resp_end", resp_vld, 0);
    do_rd(4'd1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
